// File: rtl/io_serial_pkg.sv
// Shared definitions for the memory-mapped serial transmitter: register map,
// STATUS/CONTROL bit positions and the frame FSM state type.
package io_serial_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int unsigned STAT_EMPTY     = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVERFLOW  = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_FLUSH  = 1;
  localparam int unsigned CTRL_ODD    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/io_serial_tx_if.sv
// IO-side register bus between the memory controller and an IO responder.
interface io_serial_tx_if #(
  parameter int unsigned IO_ADDR_BITS = 2
) ();
  logic [IO_ADDR_BITS-1:0] addressIO;
  logic [31:0]             dataInIO;
  logic [31:0]             dataOutIO;
  logic                    wEnIO;

  modport master (output addressIO, output dataInIO, output wEnIO, input dataOutIO);
  modport slave  (input addressIO, input dataInIO, input wEnIO, output dataOutIO);
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module io_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/io_serial_tx.sv
// Memory-mapped 8N1 serial transmitter with TX FIFO and programmable bit period.
// Define IO_SERIAL_PARITY_EN to insert a parity bit (CONTROL[2] selects odd).
module io_serial_tx
  import io_serial_pkg::*;
#(
  parameter int unsigned          IO_ADDR_BITS = 2,
  parameter int unsigned          FIFO_DEPTH   = 8,
  parameter int unsigned          DIV_BITS     = 16,
  parameter logic [DIV_BITS-1:0]  DEFAULT_DIV  = DIV_BITS'(433)
) (
  input  logic              clk,
  input  logic              rst,
  io_serial_tx_if.slave     bus,
  output logic              txd,
  output logic              txIrq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
`ifdef IO_SERIAL_PARITY_EN
  localparam tx_state_e AFTER_DATA = StParity;
`else
  localparam tx_state_e AFTER_DATA = StStop;
`endif

  logic [IO_ADDR_BITS-1:0] addr;
  logic [1:0]              sel;
  logic [31:0]             wdata, rdata;
  logic                    wen, unused_wdata;

  assign addr         = bus.addressIO;
  assign sel          = addr[1:0];
  assign wdata        = bus.dataInIO;
  assign wen          = bus.wEnIO;
  assign unused_wdata = ^wdata;

  logic          push, pop, flush, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  assign push  = wen && (sel == REG_TXDATA);
  assign flush = wen && (sel == REG_CONTROL) && wdata[CTRL_FLUSH];

  io_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic                enable_q, ovf_q, par_bit, busy;
  logic [DIV_BITS-1:0] div_q;
`ifdef IO_SERIAL_PARITY_EN
  logic                odd_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
`ifdef IO_SERIAL_PARITY_EN
      odd_q    <= 1'b0;
`endif
    end else begin
      // A push that finds the FIFO full is only lost when nothing leaves that cycle.
      if (wen && (sel == REG_STATUS) && wdata[STAT_OVERFLOW]) ovf_q <= 1'b0;
      else if (push && fifo_full && !pop)                     ovf_q <= 1'b1;
      if (wen && (sel == REG_DIVISOR)) div_q <= wdata[DIV_BITS-1:0];
      if (wen && (sel == REG_CONTROL)) begin
        enable_q <= wdata[CTRL_ENABLE];
`ifdef IO_SERIAL_PARITY_EN
        odd_q    <= wdata[CTRL_ODD];
`endif
      end
    end
  end

  tx_state_e           state_q, state_d;
  logic [DIV_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          data_q, data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
    end
  end

  // Each bit lasts bit_cnt+1 clocks; the counter reloads from the live divisor at every boundary.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    pop       = 1'b0;
    if (state_q == StIdle) begin
      if (enable_q && !fifo_empty) begin
        pop       = 1'b1;
        data_d    = fifo_rdata;
        bit_cnt_d = div_q;
        bit_idx_d = '0;
        state_d   = StStart;
      end
    end else if (bit_cnt_q != '0) begin
      bit_cnt_d = bit_cnt_q - 1'b1;
    end else begin
      bit_cnt_d = div_q;
      case (state_q)
        StStart:  state_d = StData;
        StData: begin
          if (bit_idx_q == 3'd7) state_d   = AFTER_DATA;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
        StParity: state_d = StStop;
        default:  state_d = StIdle;
      endcase
    end
  end

`ifdef IO_SERIAL_PARITY_EN
  assign par_bit = (^data_q) ^ odd_q;
`else
  assign par_bit = 1'b1;
`endif

  always_comb begin
    case (state_q)
      StStart:  txd = 1'b0;
      StData:   txd = data_q[bit_idx_q];
      StParity: txd = par_bit;
      default:  txd = 1'b1;
    endcase
    busy  = (state_q != StIdle);
    txIrq = fifo_empty && !busy && enable_q;
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_STATUS: begin
        rdata[STAT_EMPTY]             = fifo_empty;
        rdata[STAT_FULL]              = fifo_full;
        rdata[STAT_BUSY]              = busy;
        rdata[STAT_OVERFLOW]          = ovf_q;
        rdata[STAT_COUNT_LSB +: CW]   = fifo_count;
      end
      REG_DIVISOR: rdata[DIV_BITS-1:0] = div_q;
      REG_CONTROL: begin
        rdata[CTRL_ENABLE] = enable_q;
`ifdef IO_SERIAL_PARITY_EN
        rdata[CTRL_ODD]    = odd_q;
`endif
      end
      default: rdata = '0;
    endcase
  end

  assign bus.dataOutIO = rdata;

endmodule

// File: tb/tb_io_serial_tx.sv
// Bench for io_serial_tx: expected txd samples are queued as bytes are written and
// compared clock by clock once the line drops for a start bit.
module tb_io_serial_tx;
  import io_serial_pkg::*;
  timeunit 1ns;
  timeprecision 1ps;

`ifdef IO_SERIAL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic txd, txIrq;

  io_serial_tx_if #(.IO_ADDR_BITS(2)) bus ();

  io_serial_tx #(
    .IO_ADDR_BITS (2),
    .FIFO_DEPTH   (8),
    .DIV_BITS     (16),
    .DEFAULT_DIV  (16'd433)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .txd   (txd),
    .txIrq (txIrq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit exp_q[$];
  bit exp_bit;
  bit sb_armed = 1'b0;
  bit sb_run   = 1'b0;
  bit ctrl_odd = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addressIO = a;
    bus.dataInIO  = d;
    bus.wEnIO     = 1'b1;
    @(negedge clk);
    bus.wEnIO     = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.addressIO = a;
    #1;
    check_eq(tag, bus.dataOutIO, exp);
  endtask

  task automatic push_bits(input bit b, input int n);
    repeat (n) exp_q.push_back(b);
  endtask

  // One frame of expected line samples; first_len covers the start bit, len every later bit.
  task automatic push_frame(input logic [7:0] b, input int first_len, input int len);
    push_bits(1'b0, first_len);
    for (int i = 0; i < 8; i++) push_bits(b[i], len);
    if (PAR_EN) push_bits((^b) ^ ctrl_odd, len);
    push_bits(1'b1, len);
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !sb_run) break;
    end
    check_eq("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_armed && !rst) begin
        if (!sb_run && exp_q.size() != 0 && txd == 1'b0) sb_run = 1'b1;
        if (sb_run) begin
          exp_bit = exp_q.pop_front();
          check_eq("txd_bit", 32'(txd), 32'(exp_bit));
          if (exp_q.size() == 0) sb_run = 1'b0;
        end else if (exp_q.size() == 0) begin
          check_eq("txd_idle", 32'(txd), 32'h1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    bus.addressIO = '0;
    bus.dataInIO  = '0;
    bus.wEnIO     = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check_eq("rst_txd", 32'(txd), 32'h1);
    check_eq("rst_irq", 32'(txIrq), 32'h0);
    rd_chk("rst_status", REG_STATUS, 32'h1);
    rd_chk("rst_div", REG_DIVISOR, 32'd433);
    rd_chk("rst_ctrl", REG_CONTROL, 32'h0);

    // Single byte, latency and bit timing
    @(negedge clk);
    sb_armed = 1'b1;
    wr(REG_DIVISOR, 32'd3);
    wr(REG_CONTROL, 32'h1);
    push_frame(8'hA5, 4, 4);
    wr(REG_TXDATA, 32'hA5);
    check_eq("lat_n1", 32'(txd), 32'h1);
    @(negedge clk);
    check_eq("lat_n2", 32'(txd), 32'h0);
    wait_drain(200);
    @(negedge clk);
    check_eq("irq_done", 32'(txIrq), 32'h1);
    rd_chk("t2_status", REG_STATUS, 32'h1);

    // Overflow, clear, ordered drain
    @(negedge clk);
    wr(REG_CONTROL, 32'h0);
    for (int i = 0; i < 9; i++) wr(REG_TXDATA, 32'h11 * (i + 1));
    rd_chk("ovf_status", REG_STATUS, 32'h0000_080A);
    wr(REG_STATUS, 32'h8);
    rd_chk("ovf_clear", REG_STATUS, 32'h0000_0802);
    for (int i = 0; i < 8; i++) begin
      if (i != 0) push_bits(1'b1, 1);
      push_frame(8'(8'h11 * (i + 1)), 4, 4);
    end
    wr(REG_CONTROL, 32'h1);
    wait_drain(1000);
    repeat (30) @(negedge clk);
    rd_chk("drain_status", REG_STATUS, 32'h1);
    check_eq("drain_irq", 32'(txIrq), 32'h1);

    // Divisor change mid-bit
    @(negedge clk);
    push_frame(8'h00, 4, 8);
    push_bits(1'b1, 1);
    push_frame(8'hFF, 8, 8);
    wr(REG_TXDATA, 32'h00);
    wr(REG_TXDATA, 32'hFF);
    wr(REG_DIVISOR, 32'd7);
    wait_drain(400);
    wr(REG_DIVISOR, 32'd3);

    // Flush mid-frame
    @(negedge clk);
    push_frame(8'h3C, 4, 4);
    wr(REG_TXDATA, 32'h3C);
    wr(REG_TXDATA, 32'h11);
    wr(REG_TXDATA, 32'h22);
    wr(REG_TXDATA, 32'h33);
    wr(REG_CONTROL, 32'h3);
    rd_chk("flush_status", REG_STATUS, 32'h5);
    rd_chk("flush_ctrl", REG_CONTROL, 32'h1);
    wait_drain(200);
    repeat (20) @(negedge clk);
    rd_chk("flush_after", REG_STATUS, 32'h1);

    // Reset mid-frame
    @(negedge clk);
    sb_armed = 1'b0;
    wr(REG_TXDATA, 32'h5A);
    repeat (8) @(negedge clk);
    rd_chk("pre_rst_busy", REG_STATUS, 32'h5);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_txd", 32'(txd), 32'h1);
    check_eq("mid_rst_irq", 32'(txIrq), 32'h0);
    rd_chk("mid_rst_status", REG_STATUS, 32'h1);
    rd_chk("mid_rst_div", REG_DIVISOR, 32'd433);
    rd_chk("mid_rst_ctrl", REG_CONTROL, 32'h0);
    rst = 1'b0;

    // Parity select (ignored without parity support)
    @(negedge clk);
    sb_armed = 1'b1;
    wr(REG_DIVISOR, 32'd1);
    wr(REG_CONTROL, 32'h5);
    ctrl_odd = PAR_EN;
    rd_chk("ctrl_odd_rb", REG_CONTROL, PAR_EN ? 32'h5 : 32'h1);
    push_frame(8'h07, 2, 2);
    wr(REG_TXDATA, 32'h07);
    wait_drain(100);
    wr(REG_CONTROL, 32'h1);
    ctrl_odd = 1'b0;
    rd_chk("ctrl_even_rb", REG_CONTROL, 32'h1);
    push_frame(8'h07, 2, 2);
    wr(REG_TXDATA, 32'h07);
    wait_drain(100);

    // DIVISOR=0, back-to-back one-clock bits
    wr(REG_DIVISOR, 32'd0);
    push_frame(8'h96, 1, 1);
    push_bits(1'b1, 1);
    push_frame(8'h69, 1, 1);
    wr(REG_TXDATA, 32'h96);
    wr(REG_TXDATA, 32'h69);
    wait_drain(100);
    repeat (5) @(negedge clk);
    rd_chk("div0_status", REG_STATUS, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
